// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding memory fetch,
// and a small prefetch queue presented to the control unit over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         mem_req,
  output logic [PC_WIDTH-1:0]          mem_addr,
  input  logic                         mem_ack,
  input  logic [31:0]                  mem_rdata,
  output logic [31:0]                  instruction,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         branch_en,
  input  logic [PC_WIDTH-1:0]          branch_target,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_STALL   = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_next;
  logic [CNT_W-1:0]    count, count_next;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic [31:0]         word_mem [DEPTH];
  logic                push, pop, not_full;
  logic                unused_target_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Branch blanks the head so no pop can happen in the redirect cycle
  assign instr_valid = (count != '0) && !branch_en;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == ST_FETCH) && mem_ack && !branch_en;
  assign mem_req     = (state == ST_FETCH) || (state == ST_DISCARD);
  assign mem_addr    = fetch_pc;
  assign instruction = word_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign queue_count = count;
  assign unused_target_bits = ^branch_target[1:0];

  always_comb begin
    count_next = count;
    if (branch_en)        count_next = '0;
    else if (push && !pop) count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  // Fetch decisions look at the post-update occupancy
  assign not_full = count_next < CNT_W'(DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_STALL;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    if (branch_en) begin
      fetch_pc_next = {branch_target[PC_WIDTH-1:2], 2'b00};
      // An unacked request cannot be withdrawn; its reply must be swallowed
      if (state == ST_FETCH || state == ST_DISCARD)
        state_next = mem_ack ? ST_FETCH : ST_DISCARD;
      else
        state_next = ST_FETCH;
    end else begin
      case (state)
        ST_STALL: begin
          if (not_full) state_next = ST_FETCH;
        end
        ST_FETCH: begin
          if (mem_ack) begin
            fetch_pc_next = fetch_pc + PC_WIDTH'(4);
            state_next    = not_full ? ST_FETCH : ST_STALL;
          end
        end
        ST_DISCARD: begin
          if (mem_ack) state_next = ST_FETCH;
        end
        default: state_next = ST_STALL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || branch_en) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      word_mem[wr_ptr] <= mem_rdata;
    end
  end

endmodule
